conv_seq_ctrl: RTL and testbench

- Sequencer for the 3x3 convolution datapath: 6-bit signed activations, 8-bit signed weights, 2-bit column-rotation `sel`, `and_control` input gating, 18-bit signed `acc`.
- Walks a 3x3 window across an IMG_H x IMG_W x NUM_CH activation map and fetches one new column per channel per step into an external 3-slot column bank.
- Uses `sel` rotation instead of shifting the bank, and gates datapath inputs outside MAC cycles.
- Accumulates `acc` over channels, then scales, saturates and emits each output pixel through a valid/ready port.

---
 rtl/conv_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// 3x3 convolution sequencer: column fetch into a rotating 3-slot bank, channel MAC, scaled output.
// Latency: first pixel 4*NUM_CH+2 cycles after start, then 2*NUM_CH+2 cycles per pixel within a row.
// Backpressure: out_valid/out_data held until out_ready; no reads are issued while stalled.
module conv_seq_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int NUM_CH = 3,
    parameter int SHIFT  = 7,
    parameter int OUT_W  = 11,
    localparam int RW = (IMG_H  > 1) ? $clog2(IMG_H)  : 1,
    localparam int CW = (IMG_W  > 1) ? $clog2(IMG_W)  : 1,
    localparam int HW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [RW-1:0]           rd_row,
    output logic [CW-1:0]           rd_col,
    output logic [HW-1:0]           rd_ch,
    output logic                    bank_we,
    output logic [1:0]              bank_slot,
    output logic [HW-1:0]           bank_ch,
    output logic [HW-1:0]           ch_sel,
    output logic [1:0]              sel,
    output logic                    and_control,
    input  logic signed [17:0]      acc_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic [RW-1:0]           out_row,
    output logic [CW-1:0]           out_col,
    output logic                    out_valid,
    input  logic                    out_ready
);
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_FETCH, S_WAIT, S_MAC, S_WRITE, S_DONE} state_t;

    localparam logic signed [19:0] SAT_HI = 20'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [19:0] SAT_LO = ~SAT_HI;

    state_t         state, nxt_state;
    logic [HW-1:0]  ch, nxt_ch;
    logic           pcol, nxt_pcol;
    logic [RW-1:0]  r, nxt_r;
    logic [CW-1:0]  c, nxt_c;
    logic [1:0]     cm, nxt_cm;
    logic [1:0]     rd_slot, fetch_slot;
    logic           last_ch;
    logic signed [19:0]      sum, sum_nxt, shifted;
    logic signed [OUT_W-1:0] sat_val;

    always_comb begin
        nxt_state = state;
        nxt_ch    = ch;
        nxt_pcol  = pcol;
        nxt_r     = r;
        nxt_c     = c;
        nxt_cm    = cm;
        last_ch   = (ch == HW'(NUM_CH - 1));
        case (state)
            S_IDLE: if (start) begin
                nxt_state = S_PRIME;
                nxt_ch    = '0;
                nxt_pcol  = 1'b0;
                nxt_r     = '0;
                nxt_c     = '0;
                nxt_cm    = 2'd0;
            end
            S_PRIME: begin
                nxt_ch = last_ch ? '0 : ch + HW'(1);
                if (last_ch) begin
                    nxt_pcol = ~pcol;
                    if (pcol) nxt_state = S_FETCH;
                end
            end
            S_FETCH: begin
                nxt_ch = last_ch ? '0 : ch + HW'(1);
                if (last_ch) nxt_state = S_WAIT;
            end
            S_WAIT: nxt_state = S_MAC;
            S_MAC: begin
                nxt_ch = last_ch ? '0 : ch + HW'(1);
                if (last_ch) nxt_state = S_WRITE;
            end
            S_WRITE: if (out_ready) begin
                if (c < CW'(IMG_W - 3)) begin
                    nxt_c     = c + CW'(1);
                    nxt_cm    = (cm == 2'd2) ? 2'd0 : cm + 2'd1;
                    nxt_state = S_FETCH;
                end else if (r < RW'(IMG_H - 3)) begin
                    nxt_r     = r + RW'(1);
                    nxt_c     = '0;
                    nxt_cm    = 2'd0;
                    nxt_state = S_PRIME;
                end else begin
                    nxt_state = S_DONE;
                end
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Column c+2 lands in slot (c+2) mod 3, tracked from c mod 3 to avoid a divider.
    assign fetch_slot = (nxt_cm == 2'd0) ? 2'd2 : nxt_cm - 2'd1;

    assign sum_nxt = sum + {{2{acc_in[17]}}, acc_in};
    assign shifted = sum_nxt >>> SHIFT;

    always_comb begin
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_HI)      sat_val = SAT_HI[OUT_W-1:0];
        else if (shifted < SAT_LO) sat_val = SAT_LO[OUT_W-1:0];
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
            ch    <= '0;
            pcol  <= 1'b0;
            r     <= '0;
            c     <= '0;
            cm    <= 2'd0;
            sum   <= '0;
        end else begin
            state <= nxt_state;
            ch    <= nxt_ch;
            pcol  <= nxt_pcol;
            r     <= nxt_r;
            c     <= nxt_c;
            cm    <= nxt_cm;
            if (state == S_WAIT)     sum <= '0;
            else if (state == S_MAC) sum <= sum_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_row      <= '0;
            rd_col      <= '0;
            rd_ch       <= '0;
            rd_slot     <= 2'd0;
            bank_we     <= 1'b0;
            bank_slot   <= 2'd0;
            bank_ch     <= '0;
            ch_sel      <= '0;
            sel         <= 2'd0;
            and_control <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_valid   <= 1'b0;
        end else begin
            busy        <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done        <= (nxt_state == S_DONE);
            rd_en       <= (nxt_state == S_PRIME) || (nxt_state == S_FETCH);
            rd_row      <= nxt_r;
            rd_col      <= (nxt_state == S_PRIME) ? CW'(nxt_pcol) : nxt_c + CW'(2);
            rd_ch       <= nxt_ch;
            rd_slot     <= (nxt_state == S_PRIME) ? {1'b0, nxt_pcol} : fetch_slot;
            bank_we     <= rd_en;
            bank_slot   <= rd_slot;
            bank_ch     <= rd_ch;
            and_control <= (nxt_state == S_MAC);
            ch_sel      <= (nxt_state == S_MAC) ? nxt_ch : '0;
            if (nxt_state == S_MAC)       sel <= nxt_cm;
            else if (nxt_state == S_IDLE) sel <= 2'd0;
            out_valid   <= (nxt_state == S_WRITE);
            if (state == S_MAC && nxt_state == S_WRITE) begin
                out_data <= sat_val;
                out_row  <= r;
                out_col  <= c;
            end
        end
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: 3x3, 6x3 and 8x8 instances share clock and reset.
module tb_conv_seq_ctrl;
    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    logic signed [17:0] acc_val;

    // 3x3 instance
    logic s3, busy3, done3, rd3, we3, ac3, ov3, rdy3;
    logic [1:0] row3, col3, ch3, slot3, bch3, chs3, sel3, orow3, ocol3;
    logic signed [17:0] acc3;
    logic signed [10:0] od3;
    assign acc3 = ac3 ? acc_val : 18'sh15555;

    conv_seq_ctrl #(.IMG_W(3), .IMG_H(3)) u3 (
        .CLK(CLK), .CLR(CLR), .start(s3), .busy(busy3), .done(done3),
        .rd_en(rd3), .rd_row(row3), .rd_col(col3), .rd_ch(ch3),
        .bank_we(we3), .bank_slot(slot3), .bank_ch(bch3), .ch_sel(chs3), .sel(sel3),
        .and_control(ac3), .acc_in(acc3), .out_data(od3), .out_row(orow3), .out_col(ocol3),
        .out_valid(ov3), .out_ready(rdy3));

    // 6x3 instance
    logic s6, busy6, done6, rd6, we6, ac6, ov6, rdy6;
    logic [1:0] row6, rch6, slot6, bch6, chs6, sel6, orow6;
    logic [2:0] rcol6, ocol6;
    logic signed [17:0] acc6;
    logic signed [10:0] od6;
    assign acc6 = ac6 ? 18'(128 * (int'(chs6) + 1)) : 18'sh15555;

    conv_seq_ctrl #(.IMG_W(6), .IMG_H(3)) u6 (
        .CLK(CLK), .CLR(CLR), .start(s6), .busy(busy6), .done(done6),
        .rd_en(rd6), .rd_row(row6), .rd_col(rcol6), .rd_ch(rch6),
        .bank_we(we6), .bank_slot(slot6), .bank_ch(bch6), .ch_sel(chs6), .sel(sel6),
        .and_control(ac6), .acc_in(acc6), .out_data(od6), .out_row(orow6), .out_col(ocol6),
        .out_valid(ov6), .out_ready(rdy6));

    // 8x8 default instance
    logic s8, busy8, done8, rd8, we8, ac8, ov8, rdy8;
    logic [2:0] rrow8, rcol8, orow8, ocol8;
    logic [1:0] rch8, slot8, bch8, chs8, sel8;
    logic signed [17:0] acc8;
    logic signed [10:0] od8;
    assign acc8 = ac8 ? 18'(128 * (int'(chs8) + 1)) : 18'sh15555;

    conv_seq_ctrl u8 (
        .CLK(CLK), .CLR(CLR), .start(s8), .busy(busy8), .done(done8),
        .rd_en(rd8), .rd_row(rrow8), .rd_col(rcol8), .rd_ch(rch8),
        .bank_we(we8), .bank_slot(slot8), .bank_ch(bch8), .ch_sel(chs8), .sel(sel8),
        .and_control(ac8), .acc_in(acc8), .out_data(od8), .out_row(orow8), .out_col(ocol8),
        .out_valid(ov8), .out_ready(rdy8));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sat_frame(input logic signed [17:0] a, input int exp, input string tag);
        int got;
        bit seen;
        got = 0;
        seen = 0;
        acc_val = a;
        s3 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            s3 = 1'b0;
            if (ov3 && !seen) begin
                seen = 1;
                got = od3;
            end
            if (done3) break;
        end
        @(posedge CLK); #1;
        chk({tag, "_seen"}, seen, 1);
        chk(tag, got, exp);
    endtask

    initial begin
        logic [31:0] m_rd, m_we, m_ac, m_ov, m_dn, m_bz;
        logic [63:0] rseq, wseq, mseq, selseq, slotseq, rcolseq, colseq;
        int cnt, bad, d3, nout, ndone, stall, stall_err, raster_err, bank_err;
        int er, ec, snap, outs_at_done, post, prev_col;
        logic [3:0] pos;
        logic [1:0] prev_ch;
        bit hit, seen, stalled;

        CLR = 1'b1; s3 = 0; s6 = 0; s8 = 0;
        rdy3 = 1; rdy6 = 1; rdy8 = 1; acc_val = 18'sd128;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_u3", {busy3, done3, rd3, we3, ac3, ov3, sel3, chs3, od3, orow3, ocol3}, 0);
        chk("reset_u8", {busy8, done8, rd8, we8, ac8, ov8, sel8, chs8, od8, orow8, ocol8}, 0);
        CLR = 1'b0;

        cnt = 0;
        repeat (10) begin
            @(posedge CLK); #1;
            if (rd8 || busy8 || rd3 || busy3) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        // Frame timing on 3x3, with a start pulse during PRIME that must be ignored
        m_rd = 0; m_we = 0; m_ac = 0; m_ov = 0; m_dn = 0; m_bz = 0;
        rseq = 0; wseq = 0; mseq = 0; bad = 0; d3 = -99; pos = 4'hF;
        s3 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            if (k == 1) s3 = 1'b0;
            if (k == 5) s3 = 1'b1;
            if (k == 6) s3 = 1'b0;
            m_rd[k] = rd3; m_we[k] = we3; m_ac[k] = ac3;
            m_ov[k] = ov3; m_dn[k] = done3; m_bz[k] = busy3;
            if (rd3) begin
                rseq = {rseq[59:0], col3, ch3};
                if (row3 != 2'd0) bad++;
            end
            if (we3) wseq = {wseq[59:0], slot3, bch3};
            if (ac3) mseq = {mseq[59:0], sel3, chs3};
            if (ov3) begin
                d3 = od3;
                pos = {orow3, ocol3};
            end
        end
        chk("t_rd_en", m_rd, 32'h3FE);
        chk("t_bank_we", m_we, 32'h7FC);
        chk("t_and_ctl", m_ac, 32'h3800);
        chk("t_out_valid", m_ov, 32'h4000);
        chk("t_done", m_dn, 32'h8000);
        chk("t_busy", m_bz, 32'h7FFE);
        chk("t_rd_seq", rseq, 64'h01245689A);
        chk("t_bank_seq", wseq, 64'h01245689A);
        chk("t_mac_seq", mseq, 64'h012);
        chk("t_data", d3, 3);
        chk("t_pos", pos, 0);
        chk("t_rd_row", bad, 0);

        sat_frame(18'sd131071, 1023, "sat_pos");
        sat_frame(-18'sd131072, -1024, "sat_neg");
        sat_frame(-18'sd1, -1, "neg_one");

        // Column rotation on 6x3
        selseq = 0; slotseq = 0; rcolseq = 0; colseq = 0; bad = 0; nout = 0; ndone = 0;
        s6 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK); #1;
            s6 = 1'b0;
            if (ov6) begin
                selseq = {selseq[59:0], 2'b00, sel6};
                colseq = {colseq[59:0], 1'b0, ocol6};
                if (od6 != 11'sd6 || orow6 != 2'd0) bad++;
                nout++;
            end
            if (we6 && bch6 == 2'd0) slotseq = {slotseq[59:0], 2'b00, slot6};
            if (rd6 && rch6 == 2'd0) rcolseq = {rcolseq[59:0], 1'b0, rcol6};
            if (rd6 && row6 != 2'd0) bad++;
            if (sel6 == 2'd3) bad++;
            if (done6) ndone++;
        end
        chk("rot_sel", selseq, 64'h0120);
        chk("rot_slot", slotseq, 64'h012012);
        chk("rot_rd_col", rcolseq, 64'h012345);
        chk("rot_out_col", colseq, 64'h0123);
        chk("rot_nout", nout, 4);
        chk("rot_done", ndone, 1);
        chk("rot_misc", bad, 0);
        chk("rot_idle", busy6, 0);

        // Abort during MAC of pixel (1,3) on 8x8
        hit = 0; seen = 0;
        s8 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge CLK); #1;
            s8 = 1'b0;
            if (ov8 && orow8 == 3'd1 && ocol8 == 3'd2) seen = 1;
            if (seen && ac8) begin
                hit = 1;
                break;
            end
        end
        chk("abort_reach", hit, 1);
        #3 CLR = 1'b1;
        #1;
        chk("abort_clear", {busy8, done8, rd8, we8, ac8, ov8, sel8, chs8, od8, orow8, ocol8,
                            rcol8, rrow8, rch8, slot8, bch8}, 0);
        @(posedge CLK); #1;
        CLR = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (done8 || busy8) cnt++;
        end
        chk("abort_quiet", cnt, 0);

        // Full 8x8 frame after abort, with a 5-cycle stall at pixel (0,2)
        er = 0; ec = 0; nout = 0; ndone = 0; stall = 0; stalled = 0; snap = 0;
        stall_err = 0; raster_err = 0; bank_err = 0; outs_at_done = -1; post = 0;
        prev_col = 0; prev_ch = 2'd0;
        s8 = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge CLK); #1;
            s8 = 1'b0;
            if (!rdy8 && rd8) stall_err++;
            if (we8 && (slot8 != 2'(prev_col % 3) || bch8 != prev_ch)) bank_err++;
            prev_col = int'(rcol8);
            prev_ch = rch8;
            if (rd8 && int'(rrow8) != er) bank_err++;
            if (ov8) begin
                if (!stalled && orow8 == 3'd0 && ocol8 == 3'd2) begin
                    stalled = 1;
                    stall = 5;
                    snap = od8;
                end
                if (stall > 0) begin
                    rdy8 = 1'b0;
                    stall--;
                    if (od8 != snap || ocol8 != 3'd2 || orow8 != 3'd0) stall_err++;
                end else begin
                    rdy8 = 1'b1;
                    if (int'(orow8) != er || int'(ocol8) != ec || od8 != 11'sd6) raster_err++;
                    nout++;
                    ec++;
                    if (ec == 6) begin
                        ec = 0;
                        er++;
                    end
                end
            end else if (stall > 0) begin
                stall_err++;
                stall = 0;
                rdy8 = 1'b1;
            end
            if (done8) begin
                ndone++;
                outs_at_done = nout;
            end
            if (ndone > 0) post++;
            if (post > 5) break;
        end
        chk("bp_stalled", stalled, 1);
        chk("bp_stable", stall_err, 0);
        chk("bp_raster", raster_err, 0);
        chk("bp_bank", bank_err, 0);
        chk("bp_nout", nout, 36);
        chk("bp_done", ndone, 1);
        chk("bp_done_after", outs_at_done, 36);
        chk("bp_idle", busy8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
